// File: rtl/mips_pkg.sv
// Shared MiniMIPS constants used by the datapath blocks.
package mips_pkg;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 32;
    localparam int DMEM_DEPTH = 256;

endpackage

// File: rtl/mips_data.sv
// MiniMIPS data memory: word-addressed, synchronous write, combinational read.
// Contents survive reset so a file preload is never disturbed by it.
module mips_data
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int DEPTH  = DMEM_DEPTH,
    parameter int ADDR_W = mips_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] address,
    input  logic              signal_mem_write,
    input  logic              signal_mem_read,
    output logic [DATA_W-1:0] read_data
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] data_memory [0:DEPTH-1];

    logic [IDX_W-1:0] index;
    logic             valid_address;

    // Full-width compare: high address bits never alias onto low words.
    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return addr < ADDR_W'(DEPTH);
    endfunction

    assign valid_address = in_range(address);
    assign index         = address[IDX_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst && signal_mem_write && valid_address) begin
            data_memory[index] <= write_data;
        end
    end

    always_comb begin
        read_data = '0;
        if (!rst && signal_mem_read && valid_address) begin
            read_data = data_memory[index];
        end
    end

endmodule

// File: tb/tb_mips_data.sv
// Self-checking bench for mips_data: directed scenarios plus a random phase
// scored against a plain array model of the memory.
module tb_mips_data;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] write_data;
    logic [31:0] address;
    logic        signal_mem_write;
    logic        signal_mem_read;
    logic [31:0] read_data;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] model_mem [DEPTH];

    mips_data dut (
        .clk              (clk),
        .rst              (rst),
        .write_data       (write_data),
        .address          (address),
        .signal_mem_write (signal_mem_write),
        .signal_mem_read  (signal_mem_read),
        .read_data        (read_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] expected_read();
        if (signal_mem_read && !rst && address < 32'(DEPTH))
            return model_mem[address];
        return 32'h0;
    endfunction

    task automatic drive(input logic r, input logic wr, input logic rd,
                         input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        rst              = r;
        signal_mem_write = wr;
        signal_mem_read  = rd;
        address          = a;
        write_data       = d;
        #1;
    endtask

    // One rising edge; the model commits the same write the memory should.
    task automatic tick();
        @(posedge clk);
        if (signal_mem_write && !rst && address < 32'(DEPTH))
            model_mem[address] = write_data;
        #1;
    endtask

    task automatic check_value(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic check_read(input string tag);
        check_value(tag, read_data, expected_read());
    endtask

    task automatic check_word(input string tag, input int idx);
        check_value(tag, dut.data_memory[idx], model_mem[idx]);
    endtask

    task automatic check_all_words(input string tag);
        int bad = 0;
        for (int i = 0; i < DEPTH; i++)
            if (dut.data_memory[i] !== model_mem[i]) bad++;
        check_value(tag, 32'(bad), 32'h0);
    endtask

    initial begin
        rst = 1'b1; signal_mem_write = 1'b0; signal_mem_read = 1'b1;
        address = 32'd0; write_data = 32'h0;

        // Reset forces read_data low even with read enabled.
        drive(1'b1, 1'b0, 1'b1, 32'd3, 32'h0);
        check_value("reset_read_zero", read_data, 32'h0);
        tick();

        // Preload every word through the write port with random data.
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 1'b1, 1'b0, 32'(i), (i == 1) ? 32'd7 : $urandom());
            tick();
        end
        check_all_words("preload_contents");

        // Preloaded word 1 = 7 reads combinationally; memory holds over 3 edges.
        drive(1'b0, 1'b0, 1'b1, 32'd1, 32'h0);
        check_value("preload_read", read_data, 32'd7);
        tick(); tick(); tick();
        check_all_words("hold_3_edges");

        // Write with read disabled, then read back.
        drive(1'b0, 1'b1, 1'b0, 32'd1, 32'd1);
        tick();
        check_value("write_word1", dut.data_memory[1], 32'd1);
        check_value("write_read_disabled", read_data, 32'h0);
        drive(1'b0, 1'b0, 1'b1, 32'd1, 32'h0);
        check_value("write_readback", read_data, 32'd1);

        // Same-cycle read and write: old word before edge, new one after.
        drive(1'b0, 1'b1, 1'b0, 32'd5, 32'hA);
        tick();
        drive(1'b0, 1'b1, 1'b1, 32'd5, 32'hB);
        check_value("rw_before_edge", read_data, 32'hA);
        tick();
        check_value("rw_after_edge", read_data, 32'hB);

        // Reset blocks the write and zeroes the read.
        drive(1'b1, 1'b1, 1'b1, 32'd2, 32'hFF);
        check_value("rst_read_zero", read_data, 32'h0);
        tick();
        check_word("rst_blocks_write", 2);
        drive(1'b0, 1'b0, 1'b1, 32'd2, 32'h0);
        check_read("rst_word_intact");

        // Out-of-range accesses: no write, no wrap, read returns 0.
        drive(1'b0, 1'b1, 1'b1, 32'd256, 32'h5);
        check_value("oor_read_256", read_data, 32'h0);
        tick();
        check_all_words("oor_write_256");
        drive(1'b0, 1'b1, 1'b1, 32'h0000_0103, 32'h6);
        check_value("oor_read_259", read_data, 32'h0);
        tick();
        check_word("oor_no_wrap", 3);
        drive(1'b0, 1'b1, 1'b1, 32'h8000_0001, 32'h7);
        tick();
        check_word("oor_high_bits", 1);

        // Both enables low.
        drive(1'b0, 1'b0, 1'b0, 32'd1, 32'hDEAD);
        check_value("enables_low", read_data, 32'h0);
        tick();
        check_all_words("enables_low_hold");

        // Random phase against the array model.
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            case ($urandom_range(0, 9))
                0:       a = $urandom();
                1:       a = 32'($urandom_range(DEPTH, DEPTH + 40));
                default: a = 32'($urandom_range(0, DEPTH - 1));
            endcase
            drive(($urandom_range(0, 15) == 0), 1'($urandom()), 1'($urandom()),
                  a, $urandom());
            check_read("rand_read_pre");
            tick();
            check_read("rand_read_post");
            if (a < 32'(DEPTH)) check_word("rand_word", int'(a));
        end
        check_all_words("final_contents");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
